// File: rtl/avr_dmem_arbiter_if.sv
// Data-memory bundle around the arbiter: core pins, RAM pins, secondary requester port, starvation status.
// slave = arbiter view; master = the surrounding core/RAM/requester view.
interface avr_dmem_arbiter_if #(
    parameter int ADDR_W = 9
);
    logic              core_re;
    logic              core_we;
    logic [ADDR_W-1:0] core_a;
    logic [7:0]        core_wdata;
    logic [7:0]        core_rdata;

    logic              ram_re;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_a;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;

    logic              sec_valid;
    logic              sec_ready;
    logic              sec_we;
    logic [ADDR_W-1:0] sec_a;
    logic [7:0]        sec_wdata;
    logic              sec_rsp_valid;
    logic [7:0]        sec_rsp_data;

    logic              starve;
    logic              starve_clr;

    modport slave (
        input  core_re, core_we, core_a, core_wdata,
        output core_rdata,
        output ram_re, ram_we, ram_a, ram_wdata,
        input  ram_rdata,
        input  sec_valid, sec_we, sec_a, sec_wdata,
        output sec_ready, sec_rsp_valid, sec_rsp_data,
        output starve,
        input  starve_clr
    );

    modport master (
        output core_re, core_we, core_a, core_wdata,
        input  core_rdata,
        input  ram_re, ram_we, ram_a, ram_wdata,
        output ram_rdata,
        output sec_valid, sec_we, sec_a, sec_wdata,
        input  sec_ready, sec_rsp_valid, sec_rsp_data,
        input  starve,
        output starve_clr
    );
endinterface

// File: rtl/avr_dmem_arbiter.sv
// Shares the data RAM between avr_core (absolute priority) and a queued secondary requester.
// Latency: secondary command issues >=1 cycle after accept; read response 1 cycle after issue.
// Backpressure: sec_ready drops when the FIFO is full; core never stalls. Option: AVR_DMEM_ARB_STARVE_EN.
module avr_dmem_arbiter #(
    parameter int ADDR_W       = 9,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    avr_dmem_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] a;
        logic [7:0]        wdata;
    } cmd_t;

    cmd_t             fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             rd_pend;
    cmd_t             head;
    logic             core_own;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    assign core_own      = bus.core_re | bus.core_we;
    assign fifo_empty    = (count == '0);
    assign bus.sec_ready = (count != CNT_W'(DEPTH));
    assign push          = bus.sec_valid & bus.sec_ready;
    assign pop           = ~core_own & ~fifo_empty;
    assign head          = fifo_mem[rd_ptr];

    // Core wins any cycle it touches memory; the idle bus keeps the head address stable.
    always_comb begin
        if (core_own) begin
            bus.ram_re    = bus.core_re;
            bus.ram_we    = bus.core_we;
            bus.ram_a     = bus.core_a;
            bus.ram_wdata = bus.core_wdata;
        end else begin
            bus.ram_re    = pop & ~head.we;
            bus.ram_we    = pop & head.we;
            bus.ram_a     = head.a;
            bus.ram_wdata = head.wdata;
        end
    end

    assign bus.core_rdata    = bus.ram_rdata;
    assign bus.sec_rsp_data  = bus.ram_rdata;
    assign bus.sec_rsp_valid = rd_pend;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{we: bus.sec_we, a: bus.sec_a, wdata: bus.sec_wdata};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_pend <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
            rd_pend <= pop & ~head.we;
        end
    end

`ifdef AVR_DMEM_ARB_STARVE_EN
    localparam int WC_W = $clog2(STARVE_LIMIT + 1);

    logic [WC_W-1:0] wait_cnt;
    logic [WC_W-1:0] wait_nxt;
    logic            starve_q;

    // Only counts cycles where a queued command is blocked by the core.
    always_comb begin
        wait_nxt = wait_cnt;
        if (pop || fifo_empty) begin
            wait_nxt = '0;
        end else if (wait_cnt != WC_W'(STARVE_LIMIT)) begin
            wait_nxt = wait_cnt + WC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
            starve_q <= 1'b0;
        end else if (bus.starve_clr) begin
            wait_cnt <= '0;
            starve_q <= 1'b0;
        end else begin
            wait_cnt <= wait_nxt;
            if (wait_nxt == WC_W'(STARVE_LIMIT)) starve_q <= 1'b1;
        end
    end

    assign bus.starve = starve_q;
`else
    logic unused_starve;
    assign unused_starve = bus.starve_clr ^ (STARVE_LIMIT != 0);
    assign bus.starve    = 1'b0;
`endif
endmodule
